// File: rtl/uart_rx_framer.sv
// 8N1 UART receiver with 16x majority-vote sampling and a valid/ready byte output.
// Define UART_PARITY_EN to receive 8E1 frames and check even parity.
module uart_rx_framer #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int DIV_RAW = CLK_HZ / (BAUD * OVERSAMPLE);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SW      = $clog2(OVERSAMPLE);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [SW-1:0] S_V0  = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_V1  = SW'(OVERSAMPLE / 2);
    localparam logic [SW-1:0] S_V2  = SW'(OVERSAMPLE / 2 + 1);
    localparam logic [SW-1:0] S_END = SW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_WAIT_HI
    } state_t;

    state_t          r_state, w_state_nxt;
    logic            r_sync1, r_sync2, r_prev;
    logic [1:0]      r_fill;
    logic [DW-1:0]   r_div_cnt;
    logic [SW-1:0]   r_smp;
    logic [2:0]      r_bit;
    logic [1:0]      r_v;
    logic [7:0]      r_shift, r_data;
    logic            r_valid, r_frame_err, r_overrun;
    logic            w_rxs, w_fall, w_tick, w_vote_t, w_bit_end, w_vote;
    logic            w_good, w_bad, w_par_err;

    assign w_rxs     = r_sync2;
    assign w_fall    = r_prev & ~w_rxs;
    assign w_tick    = (r_state != S_IDLE) && (r_div_cnt == DIV_LAST);
    assign w_vote_t  = w_tick && (r_smp == S_V2);
    assign w_bit_end = w_tick && (r_smp == S_END);
    assign w_vote    = (r_v[0] & r_v[1]) | (r_v[0] & w_rxs) | (r_v[1] & w_rxs);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // The stop state exits at its vote tick so a following start edge is never missed.
    always_comb begin
        w_state_nxt = r_state;
        w_good      = 1'b0;
        w_bad       = 1'b0;
        case (r_state)
            S_IDLE:    if (w_fall) w_state_nxt = S_START;
            S_START: begin
                if (w_vote_t && w_vote) w_state_nxt = S_IDLE;
                else if (w_bit_end)     w_state_nxt = S_DATA;
            end
`ifdef UART_PARITY_EN
            S_DATA:    if (w_bit_end && r_bit == 3'd7) w_state_nxt = S_PARITY;
            S_PARITY:  if (w_bit_end) w_state_nxt = S_STOP;
`else
            S_DATA:    if (w_bit_end && r_bit == 3'd7) w_state_nxt = S_STOP;
`endif
            S_STOP: begin
                if (w_vote_t) begin
                    w_good      = w_vote & ~w_par_err;
                    w_bad       = ~(w_vote & ~w_par_err);
                    w_state_nxt = w_vote ? S_IDLE : S_WAIT_HI;
                end
            end
            S_WAIT_HI: if (w_rxs) w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    // r_fill marks when r_sync2 holds a real pin sample, so a line held low
    // through reset release is not mistaken for a start edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_fill    <= 2'b00;
            r_prev    <= 1'b0;
            r_div_cnt <= '0;
            r_smp     <= '0;
            r_bit     <= '0;
            r_v       <= '0;
            r_shift   <= '0;
        end else begin
            r_sync1 <= rxd;
            r_sync2 <= r_sync1;
            r_fill  <= {r_fill[0], 1'b1};
            r_prev  <= r_fill[1] & r_sync2;
            if (r_state == S_IDLE) begin
                r_div_cnt <= '0;
                r_smp     <= '0;
                r_bit     <= '0;
            end else if (w_tick) begin
                r_div_cnt <= '0;
                r_smp     <= (r_smp == S_END) ? '0 : r_smp + 1'b1;
                if (r_smp == S_V0) r_v[0] <= w_rxs;
                if (r_smp == S_V1) r_v[1] <= w_rxs;
                if (r_state == S_DATA && r_smp == S_V2)  r_shift <= {w_vote, r_shift[7:1]};
                if (r_state == S_DATA && r_smp == S_END) r_bit   <= r_bit + 1'b1;
            end else begin
                r_div_cnt <= r_div_cnt + 1'b1;
            end
        end
    end

`ifdef UART_PARITY_EN
    logic r_par_err;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                                  r_par_err <= 1'b0;
        else if (r_state == S_IDLE)                  r_par_err <= 1'b0;
        else if (r_state == S_PARITY && w_vote_t)    r_par_err <= w_vote ^ (^r_shift);
    end
    assign w_par_err = r_par_err;
`else
    assign w_par_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= w_bad;
            r_overrun   <= 1'b0;
            if (w_good) begin
                if (!r_valid || rx_ready) begin
                    r_data  <= r_shift;
                    r_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (rx_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign rx_data   = r_data;
    assign rx_valid  = r_valid;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;
    assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_framer.sv
// Scoreboard bench for uart_rx_framer: 16 cycles per bit, frame outcomes predicted from the line format.
module tb_uart_rx_framer;
`ifdef UART_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int BIT_CYC = 16;
    localparam int EV_ACC = 1, EV_FERR = 2, EV_OVR = 3;

    logic       clk = 1'b0, reset = 1'b1, rxd = 1'b1, rx_ready = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid, frame_err, overrun, busy;

    int n_chk = 0, n_pass = 0;
    int exp_q[$];
    bit m_hold = 1'b0;
    logic [7:0] m_byte = '0;

    always #5 clk = ~clk;

    uart_rx_framer #(.CLK_HZ(1_000_000), .BAUD(62500), .OVERSAMPLE(16)) dut (
        .clk(clk), .reset(reset), .rxd(rxd), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .frame_err(frame_err), .overrun(overrun), .busy(busy)
    );

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic observe(input int code);
        if (exp_q.size() == 0) check("unexpected_event", code, 0);
        else check("event", code, exp_q.pop_front());
    endtask

    // Reference: a frame is good when its stop bit is 1 and (with parity) the
    // parity bit equals the XOR of the data; then it is consumed, held, or dropped.
    function automatic void model_frame(input logic [7:0] d, input bit stop_b, input bit par_b);
        bit good;
        good = stop_b && (!PAR || (par_b == ^d));
        if (!good)          exp_q.push_back(EV_FERR << 8);
        else if (rx_ready)  exp_q.push_back((EV_ACC << 8) | int'(d));
        else if (m_hold)    exp_q.push_back(EV_OVR << 8);
        else begin
            m_hold = 1'b1;
            m_byte = d;
        end
    endfunction

    task automatic drive_bit(input logic v);
        rxd = v;
        repeat (BIT_CYC) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (PAR) drive_bit(par_b);
        drive_bit(stop_b);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (reset) begin
                if (frame_err)           observe(EV_FERR << 8);
                if (overrun)             observe(EV_OVR << 8);
                if (rx_valid && rx_ready) observe((EV_ACC << 8) | int'(rx_data));
            end
        end
    end

    initial begin
        logic [7:0] d;
        bit sb, pb;
        #1 reset = 1'b0;
        wait_cyc(3);
        check("reset_rx_data", int'(rx_data), 0);
        check("reset_rx_valid", int'(rx_valid), 0);
        check("reset_frame_err", int'(frame_err), 0);
        check("reset_overrun", int'(overrun), 0);
        check("reset_busy", int'(busy), 0);
        reset = 1'b1;
        wait_cyc(20);

        // single byte, consumer ready
        model_frame(8'hA5, 1'b1, ^8'hA5);
        send_frame(8'hA5, 1'b1, ^8'hA5);
        wait_cyc(20);

        // back-to-back with consumer stalled: second byte is an overrun
        rx_ready = 1'b0;
        model_frame(8'h3C, 1'b1, ^8'h3C);
        send_frame(8'h3C, 1'b1, ^8'h3C);
        model_frame(8'h81, 1'b1, ^8'h81);
        send_frame(8'h81, 1'b1, ^8'h81);
        wait_cyc(20);
        check("stall_rx_valid", int'(rx_valid), 1);
        check("stall_rx_data", int'(rx_data), 8'h3C);
        if (m_hold) exp_q.push_back((EV_ACC << 8) | int'(m_byte));
        m_hold = 1'b0;
        rx_ready = 1'b1;
        wait_cyc(5);
        check("drained_rx_valid", int'(rx_valid), 0);

        // false start: short low glitch
        rxd = 1'b0;
        wait_cyc(4);
        check("glitch_busy", int'(busy), 1);
        rxd = 1'b1;
        wait_cyc(30);
        check("false_start_busy", int'(busy), 0);

        // bad stop bit, line held low: frame error then break guard
        model_frame(8'h55, 1'b0, ^8'h55);
        send_frame(8'h55, 1'b0, ^8'h55);
        wait_cyc(40);
        check("break_busy", int'(busy), 1);
        rxd = 1'b1;
        wait_cyc(6);
        check("break_release_busy", int'(busy), 0);
        wait_cyc(10);

        // reset in the middle of bit 4 of 0xFF, released with the line low
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        wait_cyc(8);
        reset = 1'b0;
        rxd = 1'b0;
        #1;
        check("midreset_busy", int'(busy), 0);
        check("midreset_rx_valid", int'(rx_valid), 0);
        check("midreset_rx_data", int'(rx_data), 0);
        wait_cyc(3);
        reset = 1'b1;
        wait_cyc(40);
        check("low_at_release_busy", int'(busy), 0);
        rxd = 1'b1;
        wait_cyc(16);
        model_frame(8'h12, 1'b1, ^8'h12);
        send_frame(8'h12, 1'b1, ^8'h12);
        wait_cyc(20);

        if (PAR) begin
            model_frame(8'h07, 1'b1, 1'b1);
            send_frame(8'h07, 1'b1, 1'b1);
            model_frame(8'h07, 1'b1, 1'b0);
            send_frame(8'h07, 1'b1, 1'b0);
            wait_cyc(20);
        end

        // randomized frames: occasional bad stop (and bad parity when enabled)
        for (int k = 0; k < 30; k++) begin
            d  = 8'($urandom);
            sb = ($urandom_range(0, 5) != 0);
            pb = (^d) ^ (PAR && ($urandom_range(0, 4) == 0));
            model_frame(d, sb, pb);
            send_frame(d, sb, pb);
            if (!sb) begin
                wait_cyc($urandom_range(4, 30));
                rxd = 1'b1;
                wait_cyc(BIT_CYC);
            end else begin
                wait_cyc($urandom_range(0, 8));
            end
        end

        wait_cyc(40);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
